denormalizer: RTL and testbench
===============================

Name: denormalizer

Overview:
- Pipelined reverse of the normalizer. It takes a calculated result (exponent plus 49-bit [xx.47] fraction) whose signed exponent is at or below the subnormal boundary.
- It right-shifts the fraction into subnormal position, collects a sticky bit from every discarded bit, and forces the exponent to zero.
- It sits between the normalizer and the rounder in the result path.
- It has two register stages and a valid/ready handshake so the rounder can stall the pipeline.

Parameters:
- EXP_WIDTH, 10, signed two's-complement width of the biased exponent.
- FRAC_WIDTH, 49, fraction width in [xx.xxx...] format (2 integer bits, FRAC_WIDTH-2 fractional bits).
- SHIFT_WIDTH, 6, width of the saturated shift count. Must satisfy 2^SHIFT_WIDTH > FRAC_WIDTH.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept an input beat this cycle.
- denormalize  in  1  enable for this beat; 0 means pass-through.
- sticky_in  in  1  sticky bit accumulated upstream.
- normalized_exponent  in  EXP_WIDTH  signed biased exponent.
- normalized_fraction  in  FRAC_WIDTH  fraction.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- denormalized_exponent  out  EXP_WIDTH  result exponent.
- denormalized_fraction  out  FRAC_WIDTH  result fraction.
- sticky_out  out  1  sticky_in OR all bits shifted out.
- subnormal  out  1  beat was shifted into the subnormal range.

Behaviour:
- Reset (reset_n low, asynchronous): stage valid bits clear, so out_valid=0. All data registers clear to 0, so denormalized_exponent=0, denormalized_fraction=0, sticky_out=0, subnormal=0. in_ready=1 after reset deasserts. A reset asserted mid-operation drops any in-flight beats; nothing is replayed.
- Transfers: a beat transfers on in_valid&&in_ready at the input and on out_valid&&out_ready at the output.
- Latency: exactly 2 cycles from input transfer to out_valid when no stall occurs. Throughput is 1 beat per cycle.
- Pipeline advance rule: s2 loads when !s2_valid || out_ready. s1 loads when !s1_valid || s2 loads. in_ready equals the s1 load condition. in_ready has no combinational path from in_valid; a combinational path from out_ready is allowed.
- A stalled stage holds all of its registers unchanged. Data registers need not be cleared when their valid bit is 0.
- Stage 1 (decide):
  - do_shift = denormalize && (normalized_exponent <= 0), compared as signed.
  - If do_shift, raw shift = 1 - normalized_exponent, computed at EXP_WIDTH+1 bits. Saturate to FRAC_WIDTH when raw >= FRAC_WIDTH. Otherwise shift = 0.
  - Register shift, do_shift, exponent, fraction, and sticky_in.
- Stage 2 (shift):
  - fraction_out = fraction >> shift (logical).
  - sticky_out = sticky_in | OR(bits shifted out). At the saturated shift of FRAC_WIDTH, fraction_out=0 and sticky_out = sticky_in | OR(all fraction bits).
  - If do_shift: exponent_out=0 and subnormal=1. Otherwise exponent, fraction and sticky pass through unchanged and subnormal=0.
- Boundary conditions:
  - exponent=1: no shift.
  - exponent=0: shift of 1.
  - exponent = most-negative value (-512): saturates to 49.
  - fraction=0 with any shift: fraction_out=0 and sticky_out=sticky_in.
  - denormalize=0 with a negative exponent: pass-through, subnormal=0.
- Simultaneous events: with out_ready=1 and both stages full, a new beat is accepted in the same cycle the oldest beat leaves. A full pipeline with out_ready=0 holds in_ready=0.

Decomposition:
- Shared package fpu_pkg holds:
  - FRAC_WIDTH=49 and EXP_WIDTH=10 defaults;
  - a struct for the {exponent, fraction, sticky} result triple;
  - a constant SUBNORMAL_EXP=0.
- One sub-module, denormalizer_right_shifter: combinational logical right shift plus sticky OR-reduction, with ports shift_count, operand, result, sticky. It mirrors the existing left shifter and is instantiated in stage 2.

Test Plan:
- exp=1, fraction=49'h0_8000_0000_0000 (bit 47 set), denormalize=1, sticky_in=0 -> 2 cycles later: exp=1, same fraction, sticky=0, subnormal=0.
- exp=0, fraction=bit47|bit0, denormalize=1 -> exp=0, fraction=bit46 only, sticky=1, subnormal=1.
- exp=-22 (10'h3EA), fraction=bit47 -> shift 23, fraction=bit24, sticky=0, subnormal=1.
- exp=-512, fraction=49'h1 -> shift saturated at 49, fraction=0, sticky=1. Repeat with fraction=0 and sticky_in=1 -> sticky=1.
- Back-to-back stream of 4 beats, out_ready held low on cycles 3-5 -> in_ready falls once both stages are full; the beats emerge in order with no loss or duplication; payloads stay stable while out_valid&&!out_ready.
- Reset asserted while 2 beats are in flight -> out_valid=0 immediately, all outputs 0; after release in_ready=1 and the next beat has latency 2.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU result-path definitions: default widths, the
// {exponent, fraction, sticky} result triple and the subnormal exponent.
package fpu_pkg;

    localparam int EXP_WIDTH     = 10;
    localparam int FRAC_WIDTH    = 49;
    localparam int SHIFT_WIDTH   = 6;
    localparam int SUBNORMAL_EXP = 0;

    typedef struct packed {
        logic [EXP_WIDTH-1:0]  exponent;
        logic [FRAC_WIDTH-1:0] fraction;
        logic                  sticky;
    } fpu_result_t;

endpackage

// File: rtl/denormalizer_right_shifter.sv
// Combinational logical right shift with sticky OR of the bits shifted out.
// Ports: shift_count, operand -> result, sticky.
module denormalizer_right_shifter #(
    parameter int WIDTH       = fpu_pkg::FRAC_WIDTH,
    parameter int SHIFT_WIDTH = fpu_pkg::SHIFT_WIDTH
) (
    input  logic [SHIFT_WIDTH-1:0] shift_count,
    input  logic [WIDTH-1:0]       operand,
    output logic [WIDTH-1:0]       result,
    output logic                   sticky
);

    logic [WIDTH-1:0] lost_mask;

    always_comb begin
        // ones in every position that falls off the bottom
        lost_mask = ~({WIDTH{1'b1}} << shift_count);
        result    = operand >> shift_count;
        sticky    = |(operand & lost_mask);
    end

endmodule

// File: rtl/denormalizer.sv
// Two-stage denormalizer: shifts results at/below the subnormal boundary
// into subnormal position. Ports: clk, reset_n, in_* handshake + payload,
// out_* handshake + denormalized exponent/fraction, sticky_out, subnormal.
module denormalizer #(
    parameter int EXP_WIDTH   = fpu_pkg::EXP_WIDTH,
    parameter int FRAC_WIDTH  = fpu_pkg::FRAC_WIDTH,
    parameter int SHIFT_WIDTH = fpu_pkg::SHIFT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  denormalize,
    input  logic                  sticky_in,
    input  logic [EXP_WIDTH-1:0]  normalized_exponent,
    input  logic [FRAC_WIDTH-1:0] normalized_fraction,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_WIDTH-1:0]  denormalized_exponent,
    output logic [FRAC_WIDTH-1:0] denormalized_fraction,
    output logic                  sticky_out,
    output logic                  subnormal
);

    import fpu_pkg::*;

    typedef struct packed {
        logic [EXP_WIDTH-1:0]  exponent;
        logic [FRAC_WIDTH-1:0] fraction;
        logic                  sticky;
    } beat_t;

    logic s1_load;
    logic s2_load;

    logic                   s1_valid_q;
    beat_t                  s1_q;
    logic                   s1_do_shift_q;
    logic [SHIFT_WIDTH-1:0] s1_shift_q;

    logic  s2_valid_q;
    beat_t s2_q;
    logic  s2_sub_q;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // stage 1: decide whether and how far to shift
    logic [EXP_WIDTH:0]     raw_shift;
    logic                   do_shift_d;
    logic [SHIFT_WIDTH-1:0] shift_d;

    always_comb begin
        // signed exponent <= 0: sign bit set or all zero
        do_shift_d = denormalize
                   && (normalized_exponent[EXP_WIDTH-1]
                   || (normalized_exponent == '0));
        raw_shift  = (EXP_WIDTH+1)'(1)
                   - {normalized_exponent[EXP_WIDTH-1],
                      normalized_exponent};
        shift_d    = '0;
        if (do_shift_d) begin
            if (raw_shift >= (EXP_WIDTH+1)'(FRAC_WIDTH)) begin
                shift_d = SHIFT_WIDTH'(FRAC_WIDTH);
            end else begin
                shift_d = raw_shift[SHIFT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_q          <= '0;
            s1_do_shift_q <= 1'b0;
            s1_shift_q    <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_q.exponent <= normalized_exponent;
                s1_q.fraction <= normalized_fraction;
                s1_q.sticky   <= sticky_in;
                s1_do_shift_q <= do_shift_d;
                s1_shift_q    <= shift_d;
            end
        end
    end

    // stage 2: shift and collect sticky
    logic [FRAC_WIDTH-1:0] shifted;
    logic                  lost_sticky;
    beat_t                 s2_d;

    denormalizer_right_shifter #(
        .WIDTH       (FRAC_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_shifter (
        .shift_count (s1_shift_q),
        .operand     (s1_q.fraction),
        .result      (shifted),
        .sticky      (lost_sticky)
    );

    always_comb begin
        s2_d = s1_q;
        if (s1_do_shift_q) begin
            s2_d.exponent = EXP_WIDTH'(SUBNORMAL_EXP);
            s2_d.fraction = shifted;
            s2_d.sticky   = s1_q.sticky | lost_sticky;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            s2_sub_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_q     <= s2_d;
                s2_sub_q <= s1_do_shift_q;
            end
        end
    end

    assign out_valid             = s2_valid_q;
    assign denormalized_exponent = s2_q.exponent;
    assign denormalized_fraction = s2_q.fraction;
    assign sticky_out            = s2_q.sticky;
    assign subnormal             = s2_sub_q;

endmodule

// File: tb/tb_denormalizer.sv
// Self-checking bench for denormalizer: vector table, stall/reset
// sequences and a randomized stream against a reference model.
module tb_denormalizer;

    import fpu_pkg::*;

    localparam int EW = 10;
    localparam int FW = 49;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          denormalize = 1'b0;
    logic          sticky_in = 1'b0;
    logic [EW-1:0] normalized_exponent = '0;
    logic [FW-1:0] normalized_fraction = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [EW-1:0] denormalized_exponent;
    logic [FW-1:0] denormalized_fraction;
    logic          sticky_out;
    logic          subnormal;

    always #5 clk = ~clk;

    denormalizer dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .denormalize           (denormalize),
        .sticky_in             (sticky_in),
        .normalized_exponent   (normalized_exponent),
        .normalized_fraction   (normalized_fraction),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .denormalized_exponent (denormalized_exponent),
        .denormalized_fraction (denormalized_fraction),
        .sticky_out            (sticky_out),
        .subnormal             (subnormal)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    typedef struct {
        fpu_result_t res;
        logic        sub;
    } exp_t;

    // Reference: bit-by-bit placement, every bit that falls below
    // position 0 goes into sticky.
    function automatic exp_t model(logic [EW-1:0] e, logic [FW-1:0] f,
                                   logic den, logic s);
        exp_t r;
        int   ev;
        int   sh;
        ev = int'($signed(e));
        r.res.exponent = e;
        r.res.fraction = f;
        r.res.sticky   = s;
        r.sub          = 1'b0;
        if (den && ev <= 0) begin
            sh = 1 - ev;
            r.res.exponent = '0;
            r.res.fraction = '0;
            r.sub          = 1'b1;
            for (int i = 0; i < FW; i++) begin
                if (i < sh) r.res.sticky = r.res.sticky | f[i];
                else r.res.fraction[i-sh] = f[i];
            end
        end
        return r;
    endfunction

    task automatic chk_out(string nm, exp_t x);
        chk({nm, "_exp"}, 64'(denormalized_exponent), 64'(x.res.exponent));
        chk({nm, "_frac"}, 64'(denormalized_fraction), 64'(x.res.fraction));
        chk({nm, "_sticky"}, 64'(sticky_out), 64'(x.res.sticky));
        chk({nm, "_sub"}, 64'(subnormal), 64'(x.sub));
    endtask

    task automatic drive(logic v, logic [EW-1:0] e, logic [FW-1:0] f,
                         logic den, logic s);
        in_valid            = v;
        normalized_exponent = e;
        normalized_fraction = f;
        denormalize         = den;
        sticky_in           = s;
    endtask

    // Entered and left at posedge+1; checks the 2-cycle latency.
    task automatic one_beat(string nm, logic [EW-1:0] e, logic [FW-1:0] f,
                            logic den, logic s, exp_t x);
        out_ready = 1'b1;
        drive(1'b1, e, f, den, s);
        #1;
        chk({nm, "_inrdy"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({nm, "_lat2"}, 64'(out_valid), 64'd1);
        chk_out(nm, x);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [EW-1:0] e;
        logic [FW-1:0] f;
        logic          den;
        logic          s;
        logic [EW-1:0] ee;
        logic [FW-1:0] fe;
        logic          se;
        logic          sube;
    } vec_t;

    vec_t vt[11];
    exp_t q[$];

    initial begin
        exp_t x;
        exp_t bx[4];
        logic [EW-1:0] be[4];
        logic [FW-1:0] bf[4];
        int sent;
        int recv;
        logic stall_prev;
        logic [EW-1:0] h_e;
        logic [FW-1:0] h_f;
        logic h_s;
        logic h_sub;

        vt[0]  = '{10'h001, 49'h0_8000_0000_0000, 1'b1, 1'b0,
                   10'h001, 49'h0_8000_0000_0000, 1'b0, 1'b0};
        vt[1]  = '{10'h000, 49'h0_8000_0000_0001, 1'b1, 1'b0,
                   10'h000, 49'h0_4000_0000_0000, 1'b1, 1'b1};
        vt[2]  = '{10'h3EA, 49'h0_8000_0000_0000, 1'b1, 1'b0,
                   10'h000, 49'h0_0000_0100_0000, 1'b0, 1'b1};
        vt[3]  = '{10'h200, 49'h0_0000_0000_0001, 1'b1, 1'b0,
                   10'h000, 49'h0, 1'b1, 1'b1};
        vt[4]  = '{10'h200, 49'h0, 1'b1, 1'b1,
                   10'h000, 49'h0, 1'b1, 1'b1};
        vt[5]  = '{10'h3FD, 49'h0, 1'b1, 1'b0,
                   10'h000, 49'h0, 1'b0, 1'b1};
        vt[6]  = '{10'h3F0, 49'h1_2345_6789_ABCD, 1'b0, 1'b1,
                   10'h3F0, 49'h1_2345_6789_ABCD, 1'b1, 1'b0};
        vt[7]  = '{10'h3D1, 49'h1_8000_0000_0000, 1'b1, 1'b0,
                   10'h000, 49'h0_0000_0000_0001, 1'b1, 1'b1};
        vt[8]  = '{10'h3D0, 49'h1_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                   10'h000, 49'h0, 1'b1, 1'b1};
        vt[9]  = '{10'h005, 49'h0_0000_0000_00FF, 1'b1, 1'b1,
                   10'h005, 49'h0_0000_0000_00FF, 1'b1, 1'b0};
        vt[10] = '{10'h3FF, 49'h0_0000_0000_0007, 1'b1, 1'b0,
                   10'h000, 49'h0_0000_0000_0001, 1'b1, 1'b1};

        // reset state
        #1;
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        x.res = '0;
        x.sub = 1'b0;
        chk_out("rst", x);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("rst_inrdy", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // directed vectors
        for (int i = 0; i < 11; i++) begin
            x.res.exponent = vt[i].ee;
            x.res.fraction = vt[i].fe;
            x.res.sticky   = vt[i].se;
            x.sub          = vt[i].sube;
            one_beat($sformatf("vec%0d", i), vt[i].e, vt[i].f,
                     vt[i].den, vt[i].s, x);
        end

        // 4 back-to-back beats, out_ready low on cycles 3..5
        be[0] = 10'h000; bf[0] = 49'h0_0000_0000_0003;
        be[1] = 10'h3EA; bf[1] = 49'h1_0000_00F0_0000;
        be[2] = 10'h010; bf[2] = 49'h0_1234_5678_9ABC;
        be[3] = 10'h200; bf[3] = 49'h0_0000_0000_0010;
        for (int i = 0; i < 4; i++) bx[i] = model(be[i], bf[i], 1'b1, 1'b0);
        sent = 0;
        recv = 0;
        for (int k = 1; k <= 12; k++) begin
            out_ready = !(k >= 3 && k <= 5);
            if (sent < 4) drive(1'b1, be[sent], bf[sent], 1'b1, 1'b0);
            else in_valid = 1'b0;
            #1;
            if (k <= 2 || k == 6)
                chk($sformatf("b2b_inrdy_hi%0d", k), 64'(in_ready), 64'd1);
            if (k >= 3 && k <= 5) begin
                chk($sformatf("b2b_inrdy_lo%0d", k), 64'(in_ready), 64'd0);
                chk($sformatf("b2b_hold_v%0d", k), 64'(out_valid), 64'd1);
                chk_out($sformatf("b2b_hold%0d", k), bx[0]);
            end
            if (out_valid && out_ready) begin
                if (recv < 4) chk_out($sformatf("b2b_out%0d", recv), bx[recv]);
                else chk("b2b_extra", 64'd1, 64'd0);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        chk("b2b_sent", 64'(sent), 64'd4);
        chk("b2b_recv", 64'(recv), 64'd4);

        // reset with two beats in flight
        out_ready = 1'b0;
        drive(1'b1, 10'h3FE, 49'h0_0000_0000_00F0, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 10'h3F8, 49'h0_0000_0000_0F00, 1'b1, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_ovalid", 64'(out_valid), 64'd0);
        x.res = '0;
        x.sub = 1'b0;
        chk_out("mid_rst", x);
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_after_ovalid", 64'(out_valid), 64'd0);
        chk("mid_after_inrdy", 64'(in_ready), 64'd1);
        one_beat("mid_next", 10'h3FB, 49'h0_0000_0000_00C3, 1'b1, 1'b0,
                 model(10'h3FB, 49'h0_0000_0000_00C3, 1'b1, 1'b0));
        chk("mid_no_replay", 64'(out_valid), 64'd0);

        // randomized stream
        stall_prev = 1'b0;
        h_e = '0; h_f = '0; h_s = 1'b0; h_sub = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic [EW-1:0] e;
            logic [FW-1:0] f;
            case ($urandom % 4)
                0: e = EW'($urandom);
                1: e = EW'(-int'($urandom_range(0, 60)));
                2: e = EW'($urandom_range(0, 3));
                default: e = EW'(-int'($urandom_range(40, 512)));
            endcase
            f = FW'({$urandom, $urandom});
            if ($urandom % 8 == 0) f = '0;
            drive(($urandom % 4) != 0, e, f, ($urandom % 4) != 0,
                  1'($urandom % 2));
            out_ready = ($urandom % 3) != 0;
            #1;
            if (stall_prev) begin
                chk("rnd_hold_v", 64'(out_valid), 64'd1);
                chk("rnd_hold_e", 64'(denormalized_exponent), 64'(h_e));
                chk("rnd_hold_f", 64'(denormalized_fraction), 64'(h_f));
                chk("rnd_hold_s", 64'(sticky_out), 64'(h_s));
                chk("rnd_hold_sub", 64'(subnormal), 64'(h_sub));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("rnd_extra", 64'd1, 64'd0);
                else chk_out("rnd", q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            h_e = denormalized_exponent;
            h_f = denormalized_fraction;
            h_s = sticky_out;
            h_sub = subnormal;
            if (in_valid && in_ready)
                q.push_back(model(e, f, denormalize, sticky_in));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                if (q.size() == 0) chk("drain_extra", 64'd1, 64'd0);
                else chk_out("drain", q.pop_front());
            end
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
